// File: rtl/key_entry_sequencer.sv
// Key entry sequencer for the A5/1 encrypt/decrypt path.
// Turns decoded keystrokes into key-buffer writes and keeps the write index.
// Once a complete key is confirmed with Enter, it launches the cipher core
// using a start/busy/done handshake.
// Overflow, underflow and premature Enter are rejected with a one-cycle err.
module key_entry_sequencer #(
  parameter int KEY_LEN = 8,
  parameter int IDX_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             key_valid,
  input  logic [7:0]       key_data,
  input  logic             is_backspace,
  input  logic             is_enter,
  input  logic             cipher_busy,
  input  logic             cipher_done,
  output logic             buf_we,
  output logic [IDX_W-1:0] buf_addr,
  output logic [7:0]       buf_wdata,
  output logic [IDX_W-1:0] index,
  output logic             key_full,
  output logic             key_empty,
  output logic             cipher_start,
  output logic             err,
  output logic [1:0]       state
);

  localparam logic [1:0] ST_ENTRY = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] KEY_LEN_I = IDX_W'(KEY_LEN);

  logic ev_bs;
  logic ev_enter;
  logic ev_char;

  // Classify the keystroke: backspace outranks enter, anything else is a character.
  always_comb begin
    ev_bs    = 1'b0;
    ev_enter = 1'b0;
    ev_char  = 1'b0;
    if (key_valid) begin
      if (is_backspace)  ev_bs    = 1'b1;
      else if (is_enter) ev_enter = 1'b1;
      else               ev_char  = 1'b1;
    end
  end

  // Sequencer state, write index and registered strobes; the strobes default low so each is a single-cycle pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_ENTRY;
      index        <= '0;
      buf_we       <= 1'b0;
      buf_addr     <= '0;
      buf_wdata    <= 8'h00;
      cipher_start <= 1'b0;
      err          <= 1'b0;
    end else begin
      buf_we       <= 1'b0;
      cipher_start <= 1'b0;
      err          <= 1'b0;
      case (state)
        ST_ENTRY: begin
          // A clear outranks any keystroke that arrives in the same cycle.
          if (clear) begin
            index <= '0;
          end else if (ev_char) begin
            if (index < KEY_LEN_I) begin
              buf_we    <= 1'b1;
              buf_addr  <= index;
              buf_wdata <= key_data;
              index     <= index + 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else if (ev_bs) begin
            // Decrement saturates at zero; the index never wraps.
            if (index != '0) index <= index - 1'b1;
            else             err   <= 1'b1;
          end else if (ev_enter) begin
            if (index == KEY_LEN_I) state <= ST_START;
            else                    err   <= 1'b1;
          end
        end
        ST_START: begin
          // Keystrokes and clear are ignored while the launch is pending.
          if (!cipher_busy) begin
            cipher_start <= 1'b1;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cipher_done) state <= ST_DONE;
        end
        default: begin
          // DONE: the key is frozen. Enter re-runs the cipher with the same key; edits are errors.
          if (clear) begin
            state <= ST_ENTRY;
            index <= '0;
          end else if (ev_enter) begin
            state <= ST_START;
          end else if (ev_char || ev_bs) begin
            err <= 1'b1;
          end
        end
      endcase
    end
  end

  assign key_full  = (index == KEY_LEN_I);
  assign key_empty = (index == '0);

endmodule

// File: tb/tb_key_entry_sequencer.sv
// Directed, table-driven bench for key_entry_sequencer.
// Hand sequences cover a clear held through RUN and a reset asserted mid-run.
module tb_key_entry_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       is_backspace = 1'b0;
  logic       is_enter = 1'b0;
  logic       cipher_busy = 1'b0;
  logic       cipher_done = 1'b0;
  logic       buf_we;
  logic [3:0] buf_addr;
  logic [7:0] buf_wdata;
  logic [3:0] index;
  logic       key_full;
  logic       key_empty;
  logic       cipher_start;
  logic       err;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] EN = 2'd0, ST = 2'd1, RU = 2'd2, DN = 2'd3;

  typedef struct packed {
    logic       kv;
    logic [7:0] kd;
    logic       bs;
    logic       en;
    logic       clr;
    logic       busy;
    logic       done;
  } in_t;

  typedef struct packed {
    in_t         i;
    logic [22:0] e;
  } vec_t;

  vec_t tbl[$];

  key_entry_sequencer #(.KEY_LEN(8), .IDX_W(4)) dut (
    .clock(clock), .reset(reset), .clear(clear), .key_valid(key_valid),
    .key_data(key_data), .is_backspace(is_backspace), .is_enter(is_enter),
    .cipher_busy(cipher_busy), .cipher_done(cipher_done),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .index(index), .key_full(key_full), .key_empty(key_empty),
    .cipher_start(cipher_start), .err(err), .state(state)
  );

  always #5 clock = ~clock;

  function automatic in_t iv(logic kv, logic [7:0] kd, logic bs, logic en,
                             logic clr, logic busy, logic done);
    in_t r;
    r.kv = kv; r.kd = kd; r.bs = bs; r.en = en;
    r.clr = clr; r.busy = busy; r.done = done;
    return r;
  endfunction

  // Expected record; full/empty are derived from the expected index for a key length of 8.
  function automatic vec_t mk(in_t i, logic we, logic [3:0] a, logic [7:0] d,
                              logic [3:0] idx, logic cs, logic er, logic [1:0] st);
    vec_t r;
    r.i = i;
    r.e = {we, a, d, idx, (idx == 4'd8), (idx == 4'd0), cs, er, st};
    return r;
  endfunction

  function automatic logic [22:0] outs();
    return {buf_we, buf_addr, buf_wdata, index, key_full, key_empty,
            cipher_start, err, state};
  endfunction

  task automatic chk(input string nm, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h (we,addr,wdata,idx,full,empty,start,err,state)",
               nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic apply(input in_t i);
    key_valid = i.kv; key_data = i.kd; is_backspace = i.bs; is_enter = i.en;
    clear = i.clr; cipher_busy = i.busy; cipher_done = i.done;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // ---- vector table ----
    tbl.push_back(mk(iv(0,8'h00,0,0,0,0,0), 0,4'd0,8'h00,4'd0,0,0,EN));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(iv(1,8'h41+8'(k),0,0,0,0,0), 1,4'(k),8'h41+8'(k),4'(k+1),0,0,EN));
    tbl.push_back(mk(iv(1,8'h49,0,0,0,0,0), 0,4'd7,8'h48,4'd8,0,1,EN)); // overflow
    tbl.push_back(mk(iv(0,8'h00,0,0,0,0,0), 0,4'd7,8'h48,4'd8,0,0,EN));
    tbl.push_back(mk(iv(0,8'h00,0,0,1,0,0), 0,4'd7,8'h48,4'd0,0,0,EN)); // clear
    tbl.push_back(mk(iv(1,8'h00,1,0,0,0,0), 0,4'd7,8'h48,4'd0,0,1,EN)); // underflow
    tbl.push_back(mk(iv(1,8'h61,0,0,0,0,0), 1,4'd0,8'h61,4'd1,0,0,EN));
    tbl.push_back(mk(iv(1,8'h62,0,0,0,0,0), 1,4'd1,8'h62,4'd2,0,0,EN));
    tbl.push_back(mk(iv(1,8'h63,0,0,0,0,0), 1,4'd2,8'h63,4'd3,0,0,EN));
    tbl.push_back(mk(iv(1,8'h00,1,0,0,0,0), 0,4'd2,8'h63,4'd2,0,0,EN)); // backspace
    tbl.push_back(mk(iv(1,8'h00,1,0,0,0,0), 0,4'd2,8'h63,4'd1,0,0,EN));
    tbl.push_back(mk(iv(1,8'h64,0,0,0,0,0), 1,4'd1,8'h64,4'd2,0,0,EN));
    tbl.push_back(mk(iv(1,8'h65,0,0,0,0,0), 1,4'd2,8'h65,4'd3,0,0,EN));
    tbl.push_back(mk(iv(1,8'h66,0,0,0,0,0), 1,4'd3,8'h66,4'd4,0,0,EN));
    tbl.push_back(mk(iv(1,8'h67,0,0,0,0,0), 1,4'd4,8'h67,4'd5,0,0,EN));
    tbl.push_back(mk(iv(1,8'h00,0,1,0,0,0), 0,4'd4,8'h67,4'd5,0,1,EN)); // premature enter
    tbl.push_back(mk(iv(1,8'h68,0,0,0,0,0), 1,4'd5,8'h68,4'd6,0,0,EN));
    tbl.push_back(mk(iv(1,8'h69,0,0,0,0,0), 1,4'd6,8'h69,4'd7,0,0,EN));
    tbl.push_back(mk(iv(1,8'h6A,0,0,0,0,0), 1,4'd7,8'h6A,4'd8,0,0,EN));
    tbl.push_back(mk(iv(1,8'h00,1,1,0,0,0), 0,4'd7,8'h6A,4'd7,0,0,EN)); // bs wins over enter
    tbl.push_back(mk(iv(1,8'h6B,0,0,0,0,0), 1,4'd7,8'h6B,4'd8,0,0,EN));
    tbl.push_back(mk(iv(1,8'h00,0,1,0,1,0), 0,4'd7,8'h6B,4'd8,0,0,ST)); // enter, busy
    tbl.push_back(mk(iv(0,8'h00,0,0,0,1,0), 0,4'd7,8'h6B,4'd8,0,0,ST));
    tbl.push_back(mk(iv(1,8'h70,0,0,0,1,0), 0,4'd7,8'h6B,4'd8,0,0,ST)); // dropped key
    tbl.push_back(mk(iv(0,8'h00,0,0,1,1,0), 0,4'd7,8'h6B,4'd8,0,0,ST)); // clear ignored
    tbl.push_back(mk(iv(0,8'h00,0,0,0,1,0), 0,4'd7,8'h6B,4'd8,0,0,ST));
    tbl.push_back(mk(iv(0,8'h00,0,0,0,0,0), 0,4'd7,8'h6B,4'd8,1,0,RU)); // start pulse
    tbl.push_back(mk(iv(0,8'h00,0,0,0,0,0), 0,4'd7,8'h6B,4'd8,0,0,RU));
    tbl.push_back(mk(iv(1,8'h71,0,0,0,0,0), 0,4'd7,8'h6B,4'd8,0,0,RU)); // dropped key
    tbl.push_back(mk(iv(0,8'h00,0,0,1,0,0), 0,4'd7,8'h6B,4'd8,0,0,RU)); // clear ignored
    tbl.push_back(mk(iv(0,8'h00,0,0,0,0,1), 0,4'd7,8'h6B,4'd8,0,0,DN)); // done
    tbl.push_back(mk(iv(1,8'h72,0,0,0,0,0), 0,4'd7,8'h6B,4'd8,0,1,DN)); // char in DONE
    tbl.push_back(mk(iv(1,8'h00,1,0,0,0,0), 0,4'd7,8'h6B,4'd8,0,1,DN)); // bs in DONE
    tbl.push_back(mk(iv(1,8'h00,0,1,0,0,0), 0,4'd7,8'h6B,4'd8,0,0,ST)); // re-run
    tbl.push_back(mk(iv(0,8'h00,0,0,0,0,0), 0,4'd7,8'h6B,4'd8,1,0,RU));
    tbl.push_back(mk(iv(0,8'h00,0,0,0,0,1), 0,4'd7,8'h6B,4'd8,0,0,DN));
    tbl.push_back(mk(iv(1,8'h73,0,0,1,0,0), 0,4'd7,8'h6B,4'd0,0,0,EN)); // clear beats key
    tbl.push_back(mk(iv(1,8'h74,0,0,0,0,0), 1,4'd0,8'h74,4'd1,0,0,EN));

    // ---- reset ----
    #1;
    chk("reset_async", outs(), {1'b0,4'd0,8'h00,4'd0,1'b0,1'b1,1'b0,1'b0,EN});
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("reset_released", outs(), {1'b0,4'd0,8'h00,4'd0,1'b0,1'b1,1'b0,1'b0,EN});

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].i);
      chk($sformatf("row%0d", i), outs(), tbl[i].e);
    end

    // ---- clear held through START/RUN takes effect at DONE ----
    for (int k = 0; k < 7; k++) apply(iv(1,8'h50+8'(k),0,0,0,0,0));
    chk("hc_full_idx", {19'd0,index}, {19'd0,4'd8});
    apply(iv(1,8'h00,0,1,0,0,0));
    chk("hc_start_st", {21'd0,state}, {21'd0,ST});
    apply(iv(0,8'h00,0,0,1,0,0));
    chk("hc_run_st", {20'd0,cipher_start,state}, {20'd0,1'b1,RU});
    apply(iv(0,8'h00,0,0,1,0,0));
    chk("hc_run_hold", {17'd0,index,state}, {17'd0,4'd8,RU});
    apply(iv(0,8'h00,0,0,1,0,1));
    chk("hc_done_st", {17'd0,index,state}, {17'd0,4'd8,DN});
    apply(iv(0,8'h00,0,0,1,0,0));
    chk("hc_cleared", {17'd0,index,state}, {17'd0,4'd0,EN});

    // ---- asynchronous reset in RUN, while the start pulse is high ----
    for (int k = 0; k < 8; k++) apply(iv(1,8'h30+8'(k),0,0,0,0,0));
    apply(iv(1,8'h00,0,1,0,0,0));
    apply(iv(0,8'h00,0,0,0,0,0));
    chk("rr_pre", {19'd0,cipher_start,index[3],state}, {19'd0,1'b1,1'b1,RU});
    #2 reset = 1'b1;
    #1;
    chk("rr_async", outs(), {1'b0,4'd0,8'h00,4'd0,1'b0,1'b1,1'b0,1'b0,EN});
    @(posedge clock);
    #1;
    chk("rr_held", outs(), {1'b0,4'd0,8'h00,4'd0,1'b0,1'b1,1'b0,1'b0,EN});
    @(negedge clock);
    reset = 1'b0;
    apply(iv(1,8'h55,0,0,0,0,0));
    chk("rr_first_char", outs(), {1'b1,4'd0,8'h55,4'd1,1'b0,1'b0,1'b0,1'b0,EN});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_entry_sequencer.md
Name: key_entry_sequencer

Overview:
- Synchronous controller that sequences key entry for the A5/1 encrypt/decrypt path.
- Consumes decoded keystroke events and maintains the key write index, replacing the free-running key counter's raw increment/decrement.
- Writes characters into the external key buffer and, once a complete key is confirmed with Enter, launches the cipher core with a start/busy/done handshake.
- Rejects illegal edits: overflow, underflow, and premature Enter.

Parameters:
KEY_LEN, 8, number of key characters that form a complete key; 1 <= KEY_LEN < 2**IDX_W
IDX_W, 4, width of index and buffer address

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  reset, asynchronous, active-high
clear  in  1  synchronous request to discard key and return to ENTRY
key_valid  in  1  one-cycle strobe: keystroke event present
key_data  in  8  character code, meaningful when key_valid
is_backspace  in  1  qualifies key_valid as backspace
is_enter  in  1  qualifies key_valid as enter
cipher_busy  in  1  cipher core cannot accept start
cipher_done  in  1  one-cycle pulse: cipher run finished
buf_we  out  1  key buffer write strobe
buf_addr  out  IDX_W  key buffer write address
buf_wdata  out  8  key buffer write data
index  out  IDX_W  current number of stored key characters
key_full  out  1  index == KEY_LEN
key_empty  out  1  index == 0
cipher_start  out  1  one-cycle start pulse to cipher core
err  out  1  one-cycle pulse: keystroke rejected
state  out  2  ENTRY=0, START=1, RUN=2, DONE=3

Behaviour:
- Reset values: state=ENTRY, index=0, buf_we=0, buf_addr=0, buf_wdata=0, cipher_start=0, err=0. key_empty=1 and key_full=0 follow from index.
- All outputs are registered except key_full/key_empty, which decode the index register combinationally.
- Event decode when key_valid=1, in priority order:
  - is_backspace → BACKSPACE (wins over is_enter)
  - else is_enter → ENTER
  - else CHAR
- Events with key_valid=0 are ignored.
- ENTRY, CHAR:
  - If index < KEY_LEN: next cycle buf_we=1, buf_addr=old index, buf_wdata=key_data, and index increments. Latency is 1 cycle.
  - If index == KEY_LEN: no write, index unchanged, err=1 next cycle.
- ENTRY, BACKSPACE:
  - If index > 0: index decrements, no buffer write.
  - If index == 0: err=1, index stays 0. There is no wrap to 2**IDX_W-1.
- ENTRY, ENTER:
  - If index == KEY_LEN: go to START.
  - Otherwise: err=1, stay in ENTRY.
- START:
  - When cipher_busy=0: cipher_start=1 for exactly one cycle, then go to RUN.
  - When cipher_busy=1: hold in START with cipher_start=0.
- RUN: wait for cipher_done=1, then go to DONE.
- Keystrokes in START, RUN and DONE produce no writes and no index change.
  - In START and RUN they are silently dropped, with no err.
  - In DONE, a CHAR or BACKSPACE gives err=1.
  - In DONE, ENTER returns to START, re-running with the same key.
- clear:
  - Honoured in ENTRY and DONE: next cycle state=ENTRY, index=0, no write, no err.
  - Ignored in START and RUN; a held clear takes effect once DONE is reached.
  - If clear and key_valid arrive in the same cycle, clear wins and the keystroke is dropped.
- buf_we, cipher_start and err are never high for more than one consecutive cycle per accepted event.
- A back-to-back key_valid on every cycle must be processed with no drop in ENTRY.
- reset asserted mid-operation, including RUN, immediately forces the reset values; cipher_start is never emitted as a partial pulse.

Test Plan:
- Reset, then 8 CHAR events 0x41..0x48 on consecutive cycles → writes at addr 0..7 with the matching data, index=8, key_full=1; a 9th CHAR 0x49 → err pulse, no write, index stays 8.
- From index=0, BACKSPACE → err pulse, index stays 0; enter 3 chars then 2 BACKSPACE → index=1, no buf_we on the backspace cycles.
- index=5 then ENTER → err, state stays ENTRY; fill to 8, assert key_valid with both is_backspace and is_enter → treated as backspace, index=7.
- Full key, ENTER with cipher_busy=1 for 4 cycles → state=START with no cipher_start; busy drops → one cipher_start pulse, state=RUN; cipher_done → state=DONE.
- DONE then ENTER → START → new cipher_start; clear during RUN → ignored; clear in DONE → state=ENTRY, index=0.
- Assert reset during RUN with index=8 → all outputs return to reset values immediately, asynchronously; the next CHAR writes addr 0.
